sd_spi_responder: RTL

SPI-mode SD response transmitter placed directly downstream of the SPI command receiver: once a command frame is decoded and handled, the control logic hands this block a response (R1 alone, or R1 plus a 32-bit trailer for R3/R7), and the block shifts it out on SPI DO. It inserts the N_CR gap of 0xFF bytes, drives DO MSB-first on SPI_CLK falling edges (SPI mode 0), and reports completion. It oversamples io_SPI_CLK with the system clock, exactly as the receiver does.

---
 rtl/sd_spi_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD response transmitter (N_CR filler, R1/R3/R7 shift-out).
// Optional R1b busy phase is enabled by defining SD_RESP_BUSY_EN.
module sd_spi_responder #(
   parameter int NCR_BYTES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_SPI_CLK,
   input  logic        io_SPI_CS,
   output logic        io_SPI_DO,
   input  logic        io_Start,
   input  logic        io_Long,
   input  logic [7:0]  io_R1,
   input  logic [31:0] io_Payload,
   input  logic        io_BusyHold,
   output logic        io_Busy,
   output logic        io_Done
);

`ifdef SD_RESP_BUSY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_NCR, ST_RESP, ST_BUSY} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_NCR, ST_RESP} state_t;
   logic unused_busy_hold;
   assign unused_busy_hold = io_BusyHold;
`endif

   state_t      state_q, state_d;
   logic        spi_clk_q;
   logic [39:0] shift_q, shift_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  fill_cnt_q, fill_cnt_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic        do_q, do_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        fall;

   assign fall      = spi_clk_q & ~io_SPI_CLK;
   assign io_SPI_DO = do_q;
   assign io_Busy   = busy_q;
   assign io_Done   = done_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         spi_clk_q  <= 1'b0;
         shift_q    <= '1;
         bit_cnt_q  <= '0;
         fill_cnt_q <= '0;
         byte_cnt_q <= '0;
         do_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         spi_clk_q  <= io_SPI_CLK;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         fill_cnt_q <= fill_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         do_q       <= do_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      fill_cnt_d = fill_cnt_q;
      byte_cnt_d = byte_cnt_q;
      do_d       = do_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io_Start && !io_SPI_CS) begin
               shift_d    = {io_R1, (io_Long ? io_Payload : 32'hFFFF_FFFF)};
               bit_cnt_d  = io_Long ? 6'd40 : 6'd8;
               byte_cnt_d = 4'(NCR_BYTES);
               fill_cnt_d = 3'd0;
               state_d    = ST_NCR;
            end
         end
         ST_NCR: begin
            // Last filler fall hands over to RESP so R1's MSB goes out on the very next fall.
            if (fall) begin
               do_d       = 1'b1;
               fill_cnt_d = fill_cnt_q + 3'd1;
               if (fill_cnt_q == 3'd7) begin
                  byte_cnt_d = byte_cnt_q - 4'd1;
                  if (byte_cnt_q <= 4'd1)
                     state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (fall) begin
               if (bit_cnt_q != 6'd0) begin
                  do_d      = shift_q[39];
                  shift_d   = {shift_q[38:0], 1'b1};
                  bit_cnt_d = bit_cnt_q - 6'd1;
`ifdef SD_RESP_BUSY_EN
               end else if (io_BusyHold) begin
                  do_d    = 1'b0;
                  state_d = ST_BUSY;
`endif
               end else begin
                  do_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`ifdef SD_RESP_BUSY_EN
         ST_BUSY: begin
            if (fall) begin
               if (io_BusyHold) begin
                  do_d = 1'b0;
               end else begin
                  do_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      // Host deselect wins over any bit activity in the same cycle.
      if (state_q != ST_IDLE && io_SPI_CS) begin
         state_d = ST_IDLE;
         do_d    = 1'b1;
         done_d  = 1'b0;
      end
      busy_d = (state_d != ST_IDLE);
   end

endmodule
